// File: rtl/usb_tx_arbiter.sv
// rtl/usb_tx_arbiter.sv - per-burst round-robin arbiter for the USB TX FIFO write port
// Optional macro USB_TX_ARB_PRIO0_EN: channel 0 wins every arbitration it takes part in.
module usb_tx_arbiter #(
    parameter int N_REQ     = 4,
    parameter int DATA_W    = 40,
    parameter int MAX_BURST = 16,
    parameter int TIMEOUT   = 64
) (
    input  logic                    Main_CLK,
    input  logic                    Main_RESET_N,
    input  logic [N_REQ-1:0]        REQ_VALID,
    input  logic [N_REQ*DATA_W-1:0] REQ_DATA,
    input  logic [N_REQ-1:0]        REQ_LAST,
    output logic [N_REQ-1:0]        REQ_READY,
    input  logic                    TX_FULL,
    output logic [DATA_W-1:0]       TX_FIFO_Data,
    output logic                    TX_FIFO_WE,
    output logic [N_REQ-1:0]        GRANT,
    output logic                    BUSY,
    output logic                    TIMEOUT_ERR
);

    localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
    localparam int BW = $clog2(MAX_BURST);
    localparam int TW = $clog2(TIMEOUT);

    typedef enum logic {IDLE = 1'b0, XFER = 1'b1} state_t;

    state_t            state;
    logic [IW-1:0]     last_ptr;
    logic [IW-1:0]     gnt_idx;
    logic [IW-1:0]     pick_idx;
    logic [IW-1:0]     scan_idx;
    logic              pick_found;
    logic [N_REQ-1:0]  arb_valid;
    logic [BW-1:0]     burst_cnt;
    logic [TW-1:0]     idle_cnt;
    logic              beat;
    logic              cur_valid;
    logic              cur_last;
    logic              watchdog;
    logic              release_burst;

    // Scan starts one past the last owner, so a channel that just finished goes last.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        scan_idx   = '0;
`ifdef USB_TX_ARB_PRIO0_EN
        arb_valid  = REQ_VALID & ~N_REQ'(1);
`else
        arb_valid  = REQ_VALID;
`endif
        for (int k = 1; k <= N_REQ; k++) begin
            scan_idx = IW'((int'(last_ptr) + k) % N_REQ);
            if (!pick_found && arb_valid[scan_idx]) begin
                pick_found = 1'b1;
                pick_idx   = scan_idx;
            end
        end
`ifdef USB_TX_ARB_PRIO0_EN
        if (REQ_VALID[0]) begin
            pick_found = 1'b1;
            pick_idx   = '0;
        end
`endif
    end

    always_comb begin
        REQ_READY    = GRANT & {N_REQ{~TX_FULL}};
        beat         = |(REQ_VALID & REQ_READY);
        cur_valid    = |(REQ_VALID & GRANT);
        cur_last     = |(REQ_VALID & REQ_LAST & GRANT);
        TX_FIFO_WE   = beat;
        TX_FIFO_Data = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (GRANT[i]) begin
                TX_FIFO_Data = TX_FIFO_Data | REQ_DATA[i*DATA_W +: DATA_W];
            end
        end
        // A full FIFO with valid data is back-pressure, not a stalled producer.
        watchdog      = (state == XFER) && !cur_valid && (idle_cnt == TW'(TIMEOUT - 1));
        release_burst = watchdog || (beat && (cur_last || (burst_cnt == BW'(MAX_BURST - 1))));
    end

    assign BUSY = (state == XFER);

    always_ff @(posedge Main_CLK or negedge Main_RESET_N) begin
        if (!Main_RESET_N) begin
            state       <= IDLE;
            GRANT       <= '0;
            gnt_idx     <= '0;
            last_ptr    <= IW'(N_REQ - 1);
            burst_cnt   <= '0;
            idle_cnt    <= '0;
            TIMEOUT_ERR <= 1'b0;
        end else begin
            TIMEOUT_ERR <= watchdog;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        state     <= XFER;
                        GRANT     <= N_REQ'(1) << pick_idx;
                        gnt_idx   <= pick_idx;
                        burst_cnt <= '0;
                        idle_cnt  <= '0;
                    end
                end
                XFER: begin
                    if (release_burst) begin
                        state <= IDLE;
                        GRANT <= '0;
`ifdef USB_TX_ARB_PRIO0_EN
                        if (gnt_idx != '0) begin
                            last_ptr <= gnt_idx;
                        end
`else
                        last_ptr <= gnt_idx;
`endif
                    end else if (beat) begin
                        burst_cnt <= burst_cnt + 1'b1;
                        idle_cnt  <= '0;
                    end else if (!cur_valid) begin
                        idle_cnt <= idle_cnt + 1'b1;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_usb_tx_arbiter.sv
// tb/tb_usb_tx_arbiter.sv - scoreboard bench for usb_tx_arbiter
module tb_usb_tx_arbiter;

    localparam int N  = 4;
    localparam int W  = 40;
    localparam int MB = 16;
    localparam int TO = 64;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic           tx_full = 1'b0;
    logic [W-1:0]   tx_data;
    logic           tx_we;
    logic [N-1:0]   grant;
    logic           busy;
    logic           timeout_err;

    usb_tx_arbiter #(.N_REQ(N), .DATA_W(W), .MAX_BURST(MB), .TIMEOUT(TO)) dut (
        .Main_CLK(clk), .Main_RESET_N(rst_n),
        .REQ_VALID(req_valid), .REQ_DATA(req_data), .REQ_LAST(req_last),
        .REQ_READY(req_ready), .TX_FULL(tx_full),
        .TX_FIFO_Data(tx_data), .TX_FIFO_WE(tx_we),
        .GRANT(grant), .BUSY(busy), .TIMEOUT_ERR(timeout_err)
    );

    always #5 clk = ~clk;

    logic [W:0]   src [N][128];
    int           hd [N];
    int           tl [N];
    logic [N-1:0] acc = '0;
    logic [N-1:0] prev_grant = '0;
    logic [W-1:0] exp_q [$];
    int           glog [$];
    int           gaplog [$];
    int           lenlog [$];
    int checks = 0, errors = 0;
    int nwr = 0, nto = 0, cyc = 0, last_beat_cyc = 0, to_cyc = 0, gap = 0, beats = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] expv);
        checks++;
        if (got !== expv) begin
            errors++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, expv);
        end
    endtask

    function automatic logic [W-1:0] mk(input int ch, input int b, input int w);
        return {8'(ch), 8'(b), 24'(w)};
    endfunction

    function automatic int oh2i(input logic [N-1:0] g);
        for (int i = 0; i < N; i++) if (g[i]) return i;
        return -1;
    endfunction

    function automatic int qat(input int q [$], input int i);
        if (i < q.size()) return q[i];
        return -1;
    endfunction

    function automatic bit pending();
        for (int i = 0; i < N; i++) if (hd[i] != tl[i]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic push_src(input int ch, input logic [W-1:0] d, input logic l);
        src[ch][tl[ch]] = {l, d};
        tl[ch]++;
    endtask

    task automatic clear_logs();
        glog.delete();
        gaplog.delete();
        lenlog.delete();
    endtask

    // Producers advance on handshakes seen before the previous edge, then outputs are sampled mid-cycle.
    task automatic step();
        logic [N-1:0]   v;
        logic [N-1:0]   l;
        logic [N*W-1:0] d;
        logic [W-1:0]   e;
        @(negedge clk);
        for (int i = 0; i < N; i++) if (acc[i]) hd[i]++;
        v = '0; l = '0; d = '0;
        for (int i = 0; i < N; i++) begin
            if (hd[i] != tl[i]) begin
                v[i] = 1'b1;
                l[i] = src[i][hd[i]][W];
                d[i*W +: W] = src[i][hd[i]][W-1:0];
            end
        end
        req_valid = v;
        req_last  = l;
        req_data  = d;
        #1;
        acc = req_valid & req_ready;
        cyc++;
        if (grant != '0 && prev_grant == '0) begin
            glog.push_back(oh2i(grant));
            gaplog.push_back(gap);
            gap   = 0;
            beats = 0;
            check("grant_onehot", 64'($onehot(grant)), 1);
            check("busy_on_grant", busy, 1);
        end
        if (tx_we) begin
            nwr++;
            beats++;
            last_beat_cyc = cyc;
            if (exp_q.size() == 0) begin
                check("sb_unexpected_write", tx_data, 0);
            end else begin
                e = exp_q.pop_front();
                check("sb_data", tx_data, e);
            end
        end
        if (tx_full) check("we_while_full", tx_we, 0);
        if (timeout_err) begin
            nto++;
            to_cyc = cyc;
        end
        if (grant == '0 && prev_grant != '0) lenlog.push_back(beats);
        if (grant == '0) gap++;
        prev_grant = grant;
    endtask

    task automatic drain(input int budget);
        int n;
        n = 0;
        while ((exp_q.size() != 0 || grant != '0 || pending()) && n < budget) begin
            step();
            n++;
        end
        check("drain_left", exp_q.size(), 0);
    endtask

    task automatic wait_writes(input int target, input int budget);
        int n;
        n = 0;
        while (nwr < target && n < budget) begin
            step();
            n++;
        end
        check("writes_reached", 64'(nwr >= target), 1);
    endtask

`ifdef USB_TX_ARB_PRIO0_EN
    int t1_order [5] = '{0, 0, 1, 2, 3};
    int t6_order [6] = '{0, 0, 0, 2, 2, 2};
`else
    int t1_order [5] = '{0, 1, 2, 3, 0};
    int t6_order [6] = '{0, 2, 0, 2, 0, 2};
`endif

    initial begin
        int bc [N];
        int base;
        int n;
        logic bad_we, bad_rdy, bad_g;
        for (int i = 0; i < N; i++) begin hd[i] = 0; tl[i] = 0; bc[i] = 0; end

        repeat (3) step();
        check("rst_grant", grant, 0);
        check("rst_busy", busy, 0);
        check("rst_timeout", timeout_err, 0);
        check("rst_ready", req_ready, 0);
        check("rst_we", tx_we, 0);
        rst_n = 1'b1;

        // 3-word bursts from all channels, channel 0 queued twice
        for (int k = 0; k < 5; k++) begin
            for (int w = 0; w < 3; w++) begin
                push_src(t1_order[k], mk(t1_order[k], bc[t1_order[k]], w), w == 2);
                exp_q.push_back(mk(t1_order[k], bc[t1_order[k]], w));
            end
            bc[t1_order[k]]++;
        end
        drain(300);
        for (int k = 0; k < 5; k++) begin
            check("t1_grant_order", qat(glog, k), t1_order[k]);
            check("t1_burst_len", qat(lenlog, k), 3);
        end
        for (int k = 1; k < 5; k++) check("t1_idle_gap", qat(gaplog, k), 1);

        // long stream hits the burst limit
        clear_logs();
        for (int w = 0; w < 20; w++) begin
            push_src(2, mk(2, 0, w), w == 19);
            exp_q.push_back(mk(2, 0, w));
        end
        drain(300);
        check("t2_grant0", qat(glog, 0), 2);
        check("t2_grant1", qat(glog, 1), 2);
        check("t2_len0", qat(lenlog, 0), MB);
        check("t2_len1", qat(lenlog, 1), 20 - MB);
        check("t2_gap", qat(gaplog, 1), 1);
        check("t2_no_timeout", nto, 0);

        // back-pressure stall mid-burst
        clear_logs();
        for (int w = 0; w < 6; w++) begin
            push_src(1, mk(1, 0, w), w == 5);
            exp_q.push_back(mk(1, 0, w));
        end
        base = nwr;
        wait_writes(base + 2, 50);
        tx_full = 1'b1;
        bad_we = 1'b0; bad_rdy = 1'b0; bad_g = 1'b0;
        repeat (100) begin
            step();
            bad_we  = bad_we | tx_we;
            bad_rdy = bad_rdy | req_ready[1];
            if (grant != 4'b0010) bad_g = 1'b1;
        end
        tx_full = 1'b0;
        check("t3_we_in_stall", bad_we, 0);
        check("t3_ready_in_stall", bad_rdy, 0);
        check("t3_grant_dropped", bad_g, 0);
        check("t3_no_timeout", nto, 0);
        drain(100);
        check("t3_len", qat(lenlog, 0), 6);
        check("t3_grants", glog.size(), 1);

        // producer stall triggers the watchdog
        clear_logs();
        push_src(3, mk(3, 0, 0), 1'b0);
        push_src(3, mk(3, 0, 1), 1'b0);
        exp_q.push_back(mk(3, 0, 0));
        exp_q.push_back(mk(3, 0, 1));
        n = 0;
        while (nto == 0 && n < 300) begin
            step();
            n++;
        end
        check("t4_timeout_seen", nto, 1);
        check("t4_timeout_delay", to_cyc - last_beat_cyc - 1, TO);
        check("t4_grant_cleared", grant, 0);
        check("t4_len", qat(lenlog, 0), 2);
        step();
        check("t4_pulse_width", timeout_err, 0);
        clear_logs();
        push_src(1, mk(1, 1, 0), 1'b1);
        push_src(0, mk(0, 2, 0), 1'b1);
        exp_q.push_back(mk(0, 2, 0));
        exp_q.push_back(mk(1, 1, 0));
        drain(100);
        check("t4_next_first", qat(glog, 0), 0);
        check("t4_next_second", qat(glog, 1), 1);

        // asynchronous reset in the middle of a burst
        clear_logs();
        for (int w = 0; w < 8; w++) begin
            push_src(1, mk(1, 3, w), w == 7);
            exp_q.push_back(mk(1, 3, w));
        end
        base = nwr;
        wait_writes(base + 3, 50);
        #2 rst_n = 1'b0;
        #1;
        check("t5_grant", grant, 0);
        check("t5_busy", busy, 0);
        check("t5_we", tx_we, 0);
        check("t5_ready", req_ready, 0);
        for (int i = 0; i < N; i++) hd[i] = tl[i];
        acc = '0;
        prev_grant = '0;
        exp_q.delete();
        repeat (2) step();
        rst_n = 1'b1;
        clear_logs();
        push_src(2, mk(2, 4, 0), 1'b1);
        push_src(0, mk(0, 4, 0), 1'b1);
        exp_q.push_back(mk(0, 4, 0));
        exp_q.push_back(mk(2, 4, 0));
        drain(100);
        check("t5_first_after_reset", qat(glog, 0), 0);
        check("t5_second_after_reset", qat(glog, 1), 2);

        // channels 0 and 2 both continuously requesting
        clear_logs();
        for (int i = 0; i < N; i++) bc[i] = 0;
        for (int b = 0; b < 3; b++) begin
            push_src(0, mk(0, 5, b), 1'b1);
            push_src(2, mk(2, 5, b), 1'b1);
        end
        for (int k = 0; k < 6; k++) begin
            exp_q.push_back(mk(t6_order[k], 5, bc[t6_order[k]]));
            bc[t6_order[k]]++;
        end
        drain(100);
        for (int k = 0; k < 6; k++) check("t6_grant_order", qat(glog, k), t6_order[k]);
        check("t6_no_timeout", nto, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
